// File: rtl/multi_mode_ff_bank.sv
// WIDTH-bit register bank whose bits behave as D/T/SR/JK flops or a shift/rotate
// register, with illegal-SR detection, a change pulse and a saturating update counter.
module multi_mode_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ser_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic             changed,
    output logic             sr_err,
    output logic [CNT_W-1:0] upd_cnt
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_D    = 3'd1,
        MODE_T    = 3'd2,
        MODE_SR   = 3'd3,
        MODE_JK   = 3'd4,
        MODE_SHL  = 3'd5,
        MODE_SHR  = 3'd6,
        MODE_ROL  = 3'd7
    } mode_t;

    logic [WIDTH-1:0] r_q;
    logic             r_changed;
    logic             r_srErr;
    logic [CNT_W-1:0] r_updCnt;
    logic [WIDTH-1:0] w_qNext;
    logic             w_srIllegal;

    always_comb begin
        w_qNext = r_q;
        case (mode_t'(mode))
            MODE_HOLD: w_qNext = r_q;
            MODE_D:    w_qNext = a;
            MODE_T:    w_qNext = r_q ^ a;
            MODE_SR: begin
                // s=r=1 is treated as hold so the bank never produces X
                for (int i = 0; i < WIDTH; i++) begin
                    case ({a[i], b[i]})
                        2'b01:   w_qNext[i] = 1'b0;
                        2'b10:   w_qNext[i] = 1'b1;
                        default: w_qNext[i] = r_q[i];
                    endcase
                end
            end
            MODE_JK: begin
                for (int i = 0; i < WIDTH; i++) begin
                    case ({a[i], b[i]})
                        2'b01:   w_qNext[i] = 1'b0;
                        2'b10:   w_qNext[i] = 1'b1;
                        2'b11:   w_qNext[i] = ~r_q[i];
                        default: w_qNext[i] = r_q[i];
                    endcase
                end
            end
            MODE_SHL:  w_qNext = {r_q[WIDTH-2:0], ser_in};
            MODE_SHR:  w_qNext = {ser_in, r_q[WIDTH-1:1]};
            MODE_ROL:  w_qNext = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            default:   w_qNext = r_q;
        endcase
    end

    assign w_srIllegal = (mode_t'(mode) == MODE_SR) && (|(a & b));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q       <= RESET_VAL;
            r_changed <= 1'b0;
            r_srErr   <= 1'b0;
            r_updCnt  <= '0;
        end else begin
            if (en) begin
                r_q       <= w_qNext;
                r_changed <= (w_qNext != r_q);
                if (r_updCnt != {CNT_W{1'b1}})
                    r_updCnt <= r_updCnt + CNT_W'(1);
            end else begin
                r_changed <= 1'b0;
            end
            // a new illegal SR update takes priority over a simultaneous clear
            if (en && w_srIllegal)
                r_srErr <= 1'b1;
            else if (clr_err)
                r_srErr <= 1'b0;
        end
    end

    assign q       = r_q;
    assign changed = r_changed;
    assign sr_err  = r_srErr;
    assign upd_cnt = r_updCnt;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Bench for multi_mode_ff_bank: directed vector table, hand sequences and random
// stimulus checked against a word-level model (two instances: 16-bit and 3-bit counters).
module tb_multi_mode_ff_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       ser_in;
    logic       clr_err;

    logic [7:0]  q, qSat;
    logic        changed, changedSat;
    logic        sr_err, srErrSat;
    logic [15:0] upd_cnt;
    logic [2:0]  updCntSat;

    int checks   = 0;
    int failures = 0;

    // word-level reference state
    int mQ, mCnt, mSat;
    bit mChanged, mErr;

    always #5 clk = ~clk;

    multi_mode_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
        .ser_in(ser_in), .clr_err(clr_err),
        .q(q), .changed(changed), .sr_err(sr_err), .upd_cnt(upd_cnt)
    );

    multi_mode_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(3)) dutSat (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
        .ser_in(ser_in), .clr_err(clr_err),
        .q(qSat), .changed(changedSat), .sr_err(srErrSat), .upd_cnt(updCntSat)
    );

    typedef struct {
        bit       rst;
        bit       en;
        bit [2:0] mode;
        bit [7:0] a;
        bit [7:0] b;
        bit       ser;
        bit       clr;
        bit [7:0] expQ;
        bit       expCh;
        bit       expErr;
        int       expCnt;
        int       expSat;
    } vec_t;

    vec_t vecs[17];

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic stepModel(input bit rst, input bit e, input bit [2:0] md,
                             input int av, input int bv, input bit ser, input bit clr);
        int nq;
        if (!rst) begin
            mQ = 'hA5; mChanged = 0; mErr = 0; mCnt = 0; mSat = 0;
            return;
        end
        if (e) begin
            case (md)
                0: nq = mQ;
                1: nq = av;
                2: nq = mQ ^ av;
                3: nq = (mQ & ~(av ^ bv)) | (av & ~bv);
                4: nq = (mQ & ~(av | bv)) | (av & ~bv) | (~mQ & av & bv);
                5: nq = (mQ << 1) | ser;
                6: nq = (mQ >> 1) | (ser << 7);
                default: nq = (mQ << 1) | (mQ >> 7);
            endcase
            nq = nq & 'hFF;
            mChanged = (nq != mQ);
            mQ = nq;
            mCnt = (mCnt < 65535) ? mCnt + 1 : mCnt;
            mSat = (mSat < 7) ? mSat + 1 : mSat;
        end else begin
            mChanged = 0;
        end
        if (e && md == 3 && (av & bv) != 0) mErr = 1;
        else if (clr) mErr = 0;
    endtask

    // drive one cycle, advance the model and compare both instances against it
    task automatic applyStimulus(input bit rst, input bit e, input bit [2:0] md,
                                 input bit [7:0] av, input bit [7:0] bv,
                                 input bit ser, input bit clr);
        reset = rst; en = e; mode = md; a = av; b = bv; ser_in = ser; clr_err = clr;
        stepModel(rst, e, md, int'(av), int'(bv), ser, clr);
        @(posedge clk);
        #1;
        checkOutput("q", int'(q), mQ);
        checkOutput("changed", int'(changed), int'(mChanged));
        checkOutput("sr_err", int'(sr_err), int'(mErr));
        checkOutput("upd_cnt", int'(upd_cnt), mCnt);
        checkOutput("q_sat", int'(qSat), mQ);
        checkOutput("upd_cnt_sat", int'(updCntSat), mSat);
    endtask

    initial begin
        //            rst en md  a      b      ser clr  q      ch err cnt sat
        vecs[0]  = '{0, 1, 2, 8'hFF, 8'h00, 0, 0, 8'hA5, 0, 0, 0,  0};
        vecs[1]  = '{0, 1, 2, 8'hFF, 8'h00, 0, 0, 8'hA5, 0, 0, 0,  0};
        vecs[2]  = '{1, 1, 1, 8'h3C, 8'h00, 0, 0, 8'h3C, 1, 0, 1,  1};
        vecs[3]  = '{1, 1, 1, 8'h3C, 8'h00, 0, 0, 8'h3C, 0, 0, 2,  2};
        vecs[4]  = '{1, 1, 1, 8'h0F, 8'h00, 0, 0, 8'h0F, 1, 0, 3,  3};
        vecs[5]  = '{1, 1, 2, 8'hFF, 8'h00, 0, 0, 8'hF0, 1, 0, 4,  4};
        vecs[6]  = '{1, 1, 4, 8'hF0, 8'h0F, 0, 0, 8'hF0, 0, 0, 5,  5};
        vecs[7]  = '{1, 1, 4, 8'hFF, 8'hFF, 0, 0, 8'h0F, 1, 0, 6,  6};
        vecs[8]  = '{1, 1, 1, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 7,  7};
        vecs[9]  = '{1, 1, 3, 8'h81, 8'h01, 0, 0, 8'h80, 1, 1, 8,  7};
        vecs[10] = '{1, 1, 0, 8'h00, 8'h00, 0, 1, 8'h80, 0, 0, 9,  7};
        vecs[11] = '{1, 1, 3, 8'h01, 8'h01, 0, 1, 8'h80, 0, 1, 10, 7};
        vecs[12] = '{1, 1, 1, 8'h81, 8'h00, 0, 1, 8'h81, 1, 0, 11, 7};
        vecs[13] = '{1, 1, 5, 8'h00, 8'h00, 1, 0, 8'h03, 1, 0, 12, 7};
        vecs[14] = '{1, 1, 6, 8'h00, 8'h00, 0, 0, 8'h01, 1, 0, 13, 7};
        vecs[15] = '{1, 1, 7, 8'h00, 8'h00, 1, 0, 8'h02, 1, 0, 14, 7};
        vecs[16] = '{1, 0, 1, 8'hFF, 8'h00, 0, 0, 8'h02, 0, 0, 14, 7};

        reset = 0; en = 0; mode = 0; a = 0; b = 0; ser_in = 0; clr_err = 0;
        mQ = 'hA5; mChanged = 0; mErr = 0; mCnt = 0; mSat = 0;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].a, vecs[i].b,
                          vecs[i].ser, vecs[i].clr);
            checkOutput($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].expQ));
            checkOutput($sformatf("vec%0d_changed", i), int'(changed), int'(vecs[i].expCh));
            checkOutput($sformatf("vec%0d_sr_err", i), int'(sr_err), int'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d_upd_cnt", i), int'(upd_cnt), vecs[i].expCnt);
            checkOutput($sformatf("vec%0d_upd_cnt_sat", i), int'(updCntSat), vecs[i].expSat);
        end

        // eight more rotations bring 02 back to itself
        for (int i = 0; i < 8; i++)
            applyStimulus(1, 1, 7, 8'h00, 8'h00, 1, 0);
        checkOutput("rol8_q", int'(q), 'h02);
        checkOutput("rol8_cnt", int'(upd_cnt), 22);

        // arm sr_err, shift, then reset mid-operation with a pending toggle
        applyStimulus(1, 1, 3, 8'h01, 8'h01, 0, 0);
        checkOutput("sr_hold_q", int'(q), 'h02);
        checkOutput("sr_hold_err", int'(sr_err), 1);
        applyStimulus(1, 1, 5, 8'h00, 8'h00, 1, 0);
        checkOutput("shl_q", int'(q), 'h05);
        applyStimulus(0, 1, 2, 8'hFF, 8'h00, 0, 0);
        checkOutput("midrst_q", int'(q), 'hA5);
        checkOutput("midrst_changed", int'(changed), 0);
        checkOutput("midrst_cnt", int'(upd_cnt), 0);
        checkOutput("midrst_err", int'(sr_err), 0);
        checkOutput("midrst_cnt_sat", int'(updCntSat), 0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 40) != 0), ($urandom_range(0, 4) != 0),
                          3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                          1'($urandom), ($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_mode_ff_bank.md
# multi_mode_ff_bank

Parametrised WIDTH-bit register bank whose bits update each clock as D, T, SR or JK flip-flops, or as a shift/rotate register, selected at run time by a mode input. It is the general-purpose storage element for control and status paths: one instance replaces a mix of single-bit D/T/SR/JK flops. It adds illegal-SR detection, a change indicator and a saturating update counter.

## Interface
- WIDTH, 8, number of storage bits (≥2)
- RESET_VAL, 0 (WIDTH bits), value loaded into q on reset
- CNT_W, 16, width of the update counter
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising clk edge
- en  input  1  update enable; 0 = hold all state
- mode  input  3  operation select (see Operation)
- a  input  WIDTH  D data / T mask / S bits / J bits, by mode
- b  input  WIDTH  R bits / K bits, by mode
- ser_in  input  1  serial input for shift modes
- clr_err  input  1  clears sr_err
- q  output  WIDTH  register contents
- changed  output  1  high for one cycle when the last update altered q
- sr_err  output  1  sticky flag: an SR update saw s=r=1 on some bit
- upd_cnt  output  CNT_W  count of enabled update cycles, saturating

## Operation
- Per-bit next value q_n[i] is computed from q[i], a[i], b[i] and mode; the bank is registered.
- mode 0 HOLD: q_n = q.
- mode 1 D: q_n = a.
- mode 2 T: q_n = q ^ a (bit toggles where a[i]=1).
- mode 3 SR: s=a[i], r=b[i]. 00 hold, 01 → 0, 10 → 1, 11 → hold bit; set sr_err.
- mode 4 JK: j=a[i], k=b[i]. 00 hold, 01 → 0, 10 → 1, 11 → ~q[i].
- mode 5 SHL: q_n = {q[WIDTH-2:0], ser_in}.
- mode 6 SHR: q_n = {ser_in, q[WIDTH-1:1]}.
- mode 7 ROL: q_n = {q[WIDTH-2:0], q[WIDTH-1]}; ser_in ignored.
- en=0: q, upd_cnt unchanged; changed driven 0; sr_err not set (clr_err still honoured).
- en=1: q ← q_n; changed ← (q_n != q); upd_cnt ← upd_cnt+1 unless all-ones (saturates, no wrap). HOLD mode with en=1 still counts.
- sr_err: set when en=1, mode=3 and any bit has a[i]&b[i]; cleared when clr_err=1. Set and clear in the same cycle → set wins. Stays 1 until cleared or reset.
- No X is ever produced. The SR 11 case is defined as hold.

## Timing
- Reset (reset=0 at a rising edge): q=RESET_VAL, changed=0, sr_err=0, upd_cnt=0. Reset overrides en, mode and clr_err. Mid-operation reset discards any pending update that cycle.
- First update is possible on the first edge with reset=1.
- Latency: inputs sampled at edge N. q, changed, sr_err and upd_cnt reflect the result after edge N, all in the same cycle. No combinational input→output paths.
- changed is a single-cycle pulse per altering update. It stays high on consecutive altering updates; e.g. T mode with a≠0 gives changed=1 every cycle.
- upd_cnt at 2^CNT_W−1 stays there on further updates.
- mode changes take effect the edge they are sampled; no pipeline state carries between modes.

## Test plan
- Reset/D: WIDTH=8, RESET_VAL=8'hA5. Hold reset=0 for 2 edges → q=A5, upd_cnt=0, sr_err=0. Release; en=1, mode=1, a=3C → q=3C, changed=1, upd_cnt=1. Repeat a=3C → changed=0, upd_cnt=2.
- T/JK: q=0F, mode=2, a=FF → q=F0. Then mode=4, a=F0, b=0F → q=F0, changed=0. Then a=FF, b=FF → q=0F.
- SR illegal: q=00, mode=3, a=81, b=01 → q=80, sr_err=1. Then mode=0, clr_err=1 → sr_err=0. Then mode=3, a=01, b=01 together with clr_err=1 → sr_err=1 (set wins), bit 0 held.
- Shift/rotate: q=81, mode=5, ser_in=1 → 03. mode=6, ser_in=0 → 01. mode=7 → 02. 8 further ROL edges → 02 again.
- Enable/saturation: CNT_W=3, en=1 for 10 cycles → upd_cnt stops at 7. en=0 with mode=1, a=FF → q unchanged, changed=0, upd_cnt=7.
- Mid-op reset: after shifting, assert reset=0 for one edge with en=1, mode=2, a=FF, clr_err=0 → q=RESET_VAL, changed=0, upd_cnt=0, sr_err=0.
